// File: rtl/otter_fetch_stage.sv
// Otter RV32I instruction fetch: PC register, synchronous imem request stage,
// one-entry skid buffer for stalls, and the registered IF/ID bundle.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_target,
  output logic [31:0] imem_addr,
  output logic        imem_rden,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_ir,
  output logic        id_valid,
  output logic        misalign_err
);

  logic [31:0] pc;
  logic        f2_valid;
  logic [31:0] f2_pc;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_ir;

  logic        redirect;
  logic [31:0] raw_target;
  logic        load_valid;
  logic [31:0] load_pc;
  logic [31:0] load_ir;

  assign imem_addr = pc;
  assign imem_rden = !RST && !stall;

  // Trap/mret outranks EX redirects; both outrank the hazard stall.
  always_comb begin
    redirect   = trap_valid || br_valid;
    raw_target = trap_valid ? trap_target : br_target;
  end

  // Source for IF/ID on a non-stalled cycle: skid first (older), then memory.
  always_comb begin
    load_valid = 1'b0;
    load_pc    = id_pc;
    load_ir    = NOP_INSTR;
    if (skid_valid) begin
      load_valid = 1'b1;
      load_pc    = skid_pc;
      load_ir    = skid_ir;
    end else if (f2_valid) begin
      load_valid = 1'b1;
      load_pc    = f2_pc;
      load_ir    = imem_rdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc           <= RESET_PC;
      f2_valid     <= 1'b0;
      f2_pc        <= '0;
      skid_valid   <= 1'b0;
      skid_pc      <= '0;
      skid_ir      <= NOP_INSTR;
      id_valid     <= 1'b0;
      id_ir        <= NOP_INSTR;
      id_pc        <= '0;
      id_pc4       <= 32'd4;
      misalign_err <= 1'b0;
    end else if (redirect) begin
      pc           <= {raw_target[31:2], 2'b00};
      f2_valid     <= 1'b0;
      skid_valid   <= 1'b0;
      id_valid     <= 1'b0;
      id_ir        <= NOP_INSTR;
      misalign_err <= |raw_target[1:0];
    end else begin
      misalign_err <= 1'b0;
      if (stall) begin
        // The word returning now would be lost next cycle, so park it.
        if (f2_valid) begin
          skid_valid <= 1'b1;
          skid_pc    <= f2_pc;
          skid_ir    <= imem_rdata;
          f2_valid   <= 1'b0;
        end
      end else begin
        pc         <= pc + 32'd4;
        f2_valid   <= 1'b1;
        f2_pc      <= pc;
        skid_valid <= 1'b0;
        id_valid   <= load_valid;
        id_ir      <= load_valid ? load_ir : NOP_INSTR;
        if (load_valid) begin
          id_pc  <= load_pc;
          id_pc4 <= load_pc + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed bench for otter_fetch_stage: reset latency, streaming, stalls,
// redirects, misaligned targets, mid-stream reset and PC wrap.
module tb_otter_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_target = '0;
  logic [31:0] imem_addr;
  logic        imem_rden;
  logic [31:0] imem_rdata = '0;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_ir;
  logic        id_valid;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  otter_fetch_stage dut (
    .CLK          (CLK),
    .RST          (RST),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .trap_valid   (trap_valid),
    .trap_target  (trap_target),
    .imem_addr    (imem_addr),
    .imem_rden    (imem_rden),
    .imem_rdata   (imem_rdata),
    .id_pc        (id_pc),
    .id_pc4       (id_pc4),
    .id_ir        (id_ir),
    .id_valid     (id_valid),
    .misalign_err (misalign_err)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // Memory image: word at byte address a is 0x00100093 + a/4.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 + (a >> 2);
  endfunction

  always @(posedge CLK) begin
    if (imem_rden) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_id(input logic [31:0] pc);
    check("id_valid", {31'd0, id_valid}, 32'd1);
    check("id_pc", id_pc, pc);
    check("id_pc4", id_pc4, pc + 32'd4);
    check("id_ir", id_ir, mem_word(pc));
  endtask

  task automatic expect_bubble();
    check("bubble_valid", {31'd0, id_valid}, 32'd0);
    check("bubble_ir", id_ir, NOP);
  endtask

  // invariants, sampled away from the active edge
  always @(negedge CLK) begin
    if (!RST) begin
      check("f2_skid_excl", {31'd0, dut.f2_valid & dut.skid_valid}, 32'd0);
      if (!id_valid) check("bubble_nop", id_ir, NOP);
    end
  end

  initial begin
    // reset
    step();
    step();
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_ir", id_ir, NOP);
    check("rst_pc", id_pc, 32'd0);
    check("rst_pc4", id_pc4, 32'd4);
    check("rst_mis", {31'd0, misalign_err}, 32'd0);
    check("rst_rden", {31'd0, imem_rden}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);

    // stream from RESET_PC, first valid on 2nd edge
    RST = 1'b0;
    step(); expect_bubble();
    check("rden_run", {31'd0, imem_rden}, 32'd1);
    step(); expect_id(32'h0);
    step(); expect_id(32'h4);

    // stall 3 cycles with 0x8 in flight
    stall = 1'b1;
    #1 check("rden_stall", {31'd0, imem_rden}, 32'd0);
    step(); expect_id(32'h4);
    check("skid_set", {31'd0, dut.skid_valid}, 32'd1);
    step(); expect_id(32'h4);
    step(); expect_id(32'h4);
    stall = 1'b0;
    step(); expect_id(32'h8);
    step(); expect_id(32'hC);
    step(); expect_id(32'h10);

    // branch to 0x40
    br_valid = 1'b1; br_target = 32'h40;
    step(); expect_bubble();
    check("br_mis", {31'd0, misalign_err}, 32'd0);
    check("br_addr", imem_addr, 32'h40);
    br_valid = 1'b0;
    step(); expect_bubble();
    step(); expect_id(32'h40);
    step(); expect_id(32'h44);

    // trap and branch together while stalled with a full skid
    stall = 1'b1;
    step(); expect_id(32'h44);
    trap_valid = 1'b1; trap_target = 32'h100;
    br_valid = 1'b1; br_target = 32'h40;
    step(); expect_bubble();
    check("trap_addr", imem_addr, 32'h100);
    check("trap_skid", {31'd0, dut.skid_valid}, 32'd0);
    trap_valid = 1'b0; br_valid = 1'b0;
    step(); expect_bubble();
    check("trap_hold", imem_addr, 32'h100);
    stall = 1'b0;
    step(); expect_bubble();
    step(); expect_id(32'h100);
    step(); expect_id(32'h104);

    // misaligned branch target
    br_valid = 1'b1; br_target = 32'h42;
    step(); expect_bubble();
    check("mis_pulse", {31'd0, misalign_err}, 32'd1);
    check("mis_addr", imem_addr, 32'h40);
    br_valid = 1'b0;
    step(); expect_bubble();
    check("mis_clear", {31'd0, misalign_err}, 32'd0);
    step(); expect_id(32'h40);

    // reset while the skid holds an instruction
    stall = 1'b1;
    step(); expect_id(32'h40);
    check("skid_pre_rst", {31'd0, dut.skid_valid}, 32'd1);
    RST = 1'b1;
    #1 check("rden_in_rst", {31'd0, imem_rden}, 32'd0);
    step();
    check("mrst_valid", {31'd0, id_valid}, 32'd0);
    check("mrst_ir", id_ir, NOP);
    check("mrst_pc", id_pc, 32'd0);
    check("mrst_pc4", id_pc4, 32'd4);
    check("mrst_addr", imem_addr, 32'd0);
    check("mrst_skid", {31'd0, dut.skid_valid}, 32'd0);
    check("mrst_f2", {31'd0, dut.f2_valid}, 32'd0);
    RST = 1'b0; stall = 1'b0;
    step(); expect_bubble();
    step(); expect_id(32'h0);
    step(); expect_id(32'h4);

    // PC wrap at the top of the address space
    br_valid = 1'b1; br_target = 32'hFFFF_FFF8;
    step(); expect_bubble();
    br_valid = 1'b0;
    step(); expect_bubble();
    step(); expect_id(32'hFFFF_FFF8);
    step(); expect_id(32'hFFFF_FFFC);
    check("wrap_pc4", id_pc4, 32'h0);
    step(); expect_id(32'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otter_fetch_stage.md
Name: otter_fetch_stage

Overview:
- Instruction-fetch front end of the pipelined Otter RV32I core, directly upstream of the instruction decoder.
- Owns the PC and drives the synchronous-read instruction memory.
- Presents a registered IF/ID bundle (pc, pc+4, instruction word, valid) whose ir[6:0], ir[14:12] and ir[30] feed the decoder.
- Handles hazard stalls, branch/jump redirects from EX and trap/mret redirects from the CSR unit, without losing or duplicating instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0013, instruction word driven on id_ir while id_valid=0 (addi x0,x0,0).

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold the IF/ID bundle and the PC.
- br_valid  in  1  EX-stage taken branch / JAL / JALR, single-cycle pulse.
- br_target  in  32  redirect address for br_valid.
- trap_valid  in  1  CSR unit: interrupt entry or mret, single-cycle pulse.
- trap_target  in  32  mtvec or mepc.
- imem_addr  out  32  instruction memory address; equals the PC register.
- imem_rden  out  1  read enable; rdata is valid on the next cycle.
- imem_rdata  in  32  instruction word for the address issued one cycle earlier.
- id_pc  out  32  PC of the instruction in the IF/ID register.
- id_pc4  out  32  id_pc + 4, modulo 2^32.
- id_ir  out  32  instruction word to the decoder.
- id_valid  out  1  IF/ID holds a real instruction.
- misalign_err  out  1  one-cycle pulse: the accepted redirect target had bits [1:0] != 0.

Behaviour:
- Internal state: pc (F1); f2_valid, f2_pc (request in flight); skid_valid, skid_pc, skid_ir (1-entry skid buffer); id_* registers.
- Reset (RST=1 at an edge):
  - pc=RESET_PC; f2_valid=0; skid_valid=0.
  - id_valid=0, id_ir=NOP_INSTR, id_pc=0, id_pc4=4, misalign_err=0.
  - imem_rden=0 while RST=1.
  - Reset overrides every other input, including a fetch in flight.
- imem_rden = !RST && !stall, combinational. imem_addr = pc always.
- Normal flow (stall=0, no redirect):
  - pc <= pc+4, wrapping 32'hFFFF_FFFC -> 0.
  - f2_valid <= 1; f2_pc <= pc.
  - IF/ID loads from the skid buffer if skid_valid, else from imem_rdata/f2_pc if f2_valid, else becomes a bubble (id_valid=0, id_ir=NOP_INSTR).
  - id_pc4 = loaded pc + 4.
- Latency: the first id_valid=1 appears on the 2nd edge after RST deasserts, with ir=mem[RESET_PC]. Steady state: one instruction per cycle.
- Stall (stall=1, no redirect):
  - pc and IF/ID hold.
  - If f2_valid=1: skid_pc <= f2_pc, skid_ir <= imem_rdata, skid_valid <= 1, f2_valid <= 0.
  - Else f2_valid stays 0.
  - skid_valid=1 and f2_valid=1 never coexist; the bench asserts this as an invariant.
- Stall release cycle:
  - skid drains into IF/ID and skid_valid <= 0.
  - In the same cycle the PC issues normally, with no bubble.
  - Program order is preserved across a stall of any length, including back-to-back stalls.
- Redirect:
  - trap_valid has priority over br_valid; both have priority over stall.
  - target = selected value with bits [1:0] forced to 0.
  - misalign_err <= 1 if the raw target bits [1:0] != 0, else 0; misalign_err is 0 in all non-redirect cycles.
  - On the redirect edge: pc <= target, f2_valid <= 0, skid_valid <= 0, id_valid <= 0, id_ir <= NOP_INSTR.
  - imem_rden is still driven by stall in the redirect cycle, but the returned data is discarded.
  - First redirected instruction reaches IF/ID 2 edges after the redirect edge.
  - Redirect while stall=1: the flush still happens and pc takes the target.
- id_valid=0 always implies id_ir=NOP_INSTR, so the decoder sees no side-effecting opcode during a bubble.

Test Plan:
- Reset then run, imem[i]=0x00100093+i: id_valid rises 2 cycles after RST low; id_pc = 0, 4, 8… each cycle; id_ir matches; id_pc4 = id_pc+4.
- Stall 3 cycles while the instruction at 0x8 is in flight: IF/ID holds pc 0x4; after release id_pc = 0x8, then 0xC, with no gaps and no duplicates; skid_valid and f2_valid are never both 1.
- br_valid with target 0x40 while the IF/ID holds 0x10: next id_valid=0 (id_ir=0x00000013) for 2 cycles, then id_pc=0x40.
- trap_valid (0x100) and br_valid (0x40) in the same cycle with stall=1: pc=0x100; stream resumes at 0x100 once stall drops; skid is discarded.
- br_target=0x42: misalign_err pulses for exactly one cycle; fetch resumes at 0x40.
- RST asserted mid-stream with skid_valid=1: next cycle all state is at reset values and the first instruction returns from RESET_PC; imem_rden=0 during RST; pc wraps 0xFFFFFFFC -> 0x0 in a separate run.
